// File: rtl/alu_pkg.sv
// Shared encodings for the handshaked ALU: funct3/funct7 decode values and FSM states.
package alu_pkg;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SRL    = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } alu_state_t;

endpackage

// File: rtl/alu_mdu_seq.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, one bit per
// cycle on operand magnitudes, followed by a single sign-fixup cycle flagged by done_o.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o
);

    localparam int unsigned CW = $clog2(XLEN);

    logic            busy_q, fix_q, neg_q, dz_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q, lo_q, d_q;

    logic            sa, sb, neg_d;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    always_comb begin
        sa    = a_i[XLEN-1] && (op_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
        sb    = b_i[XLEN-1] && (op_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
        mag_a = sa ? -a_i : a_i;
        mag_b = sb ? -b_i : b_i;
        case (op_i)
            F3_MULHSU, F3_REM:           neg_d = sa;
            F3_MULHU, F3_DIVU, F3_REMU:  neg_d = 1'b0;
            default:                     neg_d = sa ^ sb;
        endcase
    end

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, d_q};
    end

    // hi_q/lo_q hold {product high, product low} for multiply and {remainder, quotient}
    // for divide; d_q is the multiplicand or divisor magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            fix_q  <= 1'b0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            d_q    <= '0;
        end else begin
            fix_q <= 1'b0;
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(XLEN - 1);
                op_q   <= op_i;
                neg_q  <= neg_d;
                dz_q   <= (b_i == '0);
                hi_q   <= '0;
                lo_q   <= mag_a;
                d_q    <= mag_b;
            end else if (busy_q) begin
                if (op_q[2]) begin
                    if (!div_diff[XLEN]) begin
                        hi_q <= div_diff[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_q <= div_sh[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
                end
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                    fix_q  <= 1'b1;
                end
            end
        end
    end

    // Signed divide by zero must still yield all ones, so it bypasses the sign fixup.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
        rem_fix  = neg_q ? -hi_q : hi_q;
        case (op_q)
            F3_MUL:                        result_o = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result_o = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               result_o = quo_fix;
            default:                       result_o = rem_fix;
        endcase
    end

    assign done_o = fix_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I/RV64I register-register ALU with registered result and back-pressure.
// Define ALU_MDU_EN to add the iterative M-extension multiply/divide unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_state_t      state_q;
    logic [XLEN-1:0] out_q;
    logic            out_valid_q;

    logic            accept, f7_md, alt;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] base_d;

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;

    // funct7 == F7_MULDIV already has bit 5 clear; the extra term only keeps decode explicit.
    assign f7_md = (funct7 == F7_MULDIV);
    assign alt   = funct7[5] && !f7_md;
    assign sh    = y[SHW-1:0];

    always_comb begin
        base_d = '0;
        case (funct3)
            F3_ADD:  base_d = alt ? (x - y) : (x + y);
            F3_SLL:  base_d = x << sh;
            F3_SLT:  base_d = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            F3_SLTU: base_d = {{(XLEN-1){1'b0}}, (x < y)};
            F3_XOR:  base_d = x ^ y;
            F3_SRL: begin
                if (alt) base_d = $signed(x) >>> sh;
                else     base_d = x >> sh;
            end
            F3_OR:   base_d = x | y;
            default: base_d = x & y;
        endcase
    end

`ifdef ALU_MDU_EN
    logic            is_m;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] mdu_res;
    logic            mdu_done;

    assign is_m = f7_md;

    alu_mdu_seq #(.XLEN(XLEN)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && is_m),
        .op_i     (funct3),
        .a_i      (x),
        .b_i      (y),
        .result_o (mdu_res),
        .done_o   (mdu_done)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MDU_EN
            cnt_q       <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_MDU_EN
            if (is_m) begin
                state_q     <= BUSY;
                cnt_q       <= SHW'(XLEN - 1);
                out_valid_q <= 1'b0;
            end else
`endif
            begin
                state_q     <= DONE;
                out_q       <= base_d;
                out_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
`ifdef ALU_MDU_EN
                BUSY: begin
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    if (mdu_done) begin
                        out_q       <= mdu_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake corner cases and
// randomized operations against an arithmetic reference model (ALU_MDU_EN aware).
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;

    int checks = 0;
    int failures = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tab[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic bit mext(input logic [6:0] f7);
`ifdef ALU_MDU_EN
        return f7 == 7'b0000001;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        if (mext(f7)) begin
            case (f3)
                3'd0: begin p = sa * sb; r = p[31:0];  end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * ub; r = p[63:32]; end
                3'd3: begin p = ua * ub; r = p[63:32]; end
                3'd4: begin
                    if (b == 0) r = '1;
                    else if (ovf) r = a;
                    else begin p = sa / sb; r = p[31:0]; end
                end
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 0) r = a;
                    else if (ovf) r = '0;
                    else begin p = sa % sb; r = p[31:0]; end
                end
                default: r = (b == 0) ? a : a % b;
            endcase
        end else begin
            case (f3)
                3'd0: r = f7[5] ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7[5]) begin p = sa >>> b[4:0]; r = p[31:0]; end
                    else r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r;
    endfunction

    // Caller is #1 past a rising edge; returns #1 past the edge on which out_valid is seen.
    task automatic run_op(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        int guard;
        funct3 = f3; funct7 = f7; x = a; y = b;
        in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        check("accept_wait", 32'(guard < 100), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = out;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic [6:0]  f7s [3];
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;

        tab.push_back('{"add",      3'd0, 7'h00, 32'd5,          32'd7,          32'd12,          1});
        tab.push_back('{"sub",      3'd0, 7'h20, 32'd5,          32'd7,          32'hFFFF_FFFE,   1});
        tab.push_back('{"sra",      3'd5, 7'h20, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000,   1});
        tab.push_back('{"srl",      3'd5, 7'h00, 32'h8000_0000,  32'h0000_0024,  32'h0800_0000,   1});
        tab.push_back('{"or",       3'd6, 7'h00, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,   1});
        tab.push_back('{"and",      3'd7, 7'h00, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,   1});
        tab.push_back('{"xor",      3'd4, 7'h00, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF00F_F00F,   1});
        tab.push_back('{"sll",      3'd1, 7'h00, 32'd1,          32'h0000_0021,  32'd2,           1});
        tab.push_back('{"slt",      3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd1,           1});
        tab.push_back('{"sltu",     3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd0,           1});
        tab.push_back('{"slt_eq",   3'd2, 7'h00, 32'd5,          32'd5,          32'd0,           1});
`ifdef ALU_MDU_EN
        tab.push_back('{"mulh",     3'd1, 7'h01, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  34});
        tab.push_back('{"mulhu",    3'd3, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34});
        tab.push_back('{"mulhsu",   3'd2, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34});
        tab.push_back('{"mul",      3'd0, 7'h01, 32'd7,          32'hFFFF_FFFA,  32'hFFFF_FFD6,  34});
        tab.push_back('{"div0",     3'd4, 7'h01, 32'd9,          32'd0,          32'hFFFF_FFFF,  34});
        tab.push_back('{"div0_neg", 3'd4, 7'h01, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFFF,  34});
        tab.push_back('{"rem0",     3'd6, 7'h01, 32'd9,          32'd0,          32'd9,          34});
        tab.push_back('{"div_ovf",  3'd4, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34});
        tab.push_back('{"rem_ovf",  3'd6, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34});
        tab.push_back('{"div_neg",  3'd4, 7'h01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
        tab.push_back('{"rem_neg",  3'd6, 7'h01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34});
        tab.push_back('{"divu",     3'd5, 7'h01, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  34});
`else
        tab.push_back('{"md_off_add", 3'd0, 7'h01, 32'd5,        32'd7,          32'd12,          1});
        tab.push_back('{"md_off_srl", 3'd5, 7'h01, 32'h8000_0000, 32'd4,         32'h0800_0000,   1});
`endif

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out",       out,            32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tab[i]) begin
            run_op(tab[i].f3, tab[i].f7, tab[i].a, tab[i].b, res, lat);
            check(tab[i].name, res, tab[i].exp);
            check({tab[i].name, "_lat"}, 32'(lat), 32'(tab[i].lat));
        end
        @(posedge clk); #1;

        // Back-to-back base operations, one result per cycle.
        funct3 = 3'd0; funct7 = 7'h00; x = 32'd0; y = 32'd100;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_out", out, 32'(i * 3 + 100));
            if (i < 3) x = 32'((i + 1) * 3);
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;

        // Back-pressure: result held, then released together with a new acceptance.
        funct3 = 3'd4; funct7 = 7'h00; x = 32'h1234; y = 32'h00FF;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_out", out, 32'h0000_12CB);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        funct3 = 3'd0; x = 32'd40; y = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_out", out, 32'd42);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            f7 = f7s[$urandom_range(0, 2)];
            a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            run_op(f3, f7, a, b, res, lat);
            check($sformatf("rand%0d_f3=%0d_f7=%02h", i, f3, f7), res, model(f3, f7, a, b));
            check($sformatf("rand%0d_lat", i), 32'(lat), mext(f7) ? 32'd34 : 32'd1);
        end
        @(posedge clk); #1;

        // Reset in the middle of a divide (counter at 10), then a clean ADD.
        funct3 = 3'd4; funct7 = 7'h01; x = 32'd100; y = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (21) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out",       out,            32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_abort_quiet", 32'(out_valid), 32'd0);
        end
        run_op(3'd0, 7'h00, 32'd1, 32'd1, res, lat);
        check("post_abort_add", res, 32'd2);
        check("post_abort_lat", 32'(lat), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
